// File: rtl/add_stream_fetch_if.sv
// Bus between the ROM prefetch stage, the combinational ROM and the downstream accumulator.
// The DUT takes the slave view; the ROM/accumulator side takes the master view.
interface add_stream_fetch_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [29:0]   mem_addr;
    logic [31:0]   mem_data;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          done;

    modport master (
        input  mem_addr,
        input  out_data,
        input  out_valid,
        input  level,
        input  done,
        output mem_data,
        output out_ready
    );

    modport slave (
        output mem_addr,
        output out_data,
        output out_valid,
        output level,
        output done,
        input  mem_data,
        input  out_ready
    );
endinterface

// File: rtl/add_stream_fetch.sv
// Prefetch stage of the adding pipeline: walks ROM word indices 0..LAST_INDEX and buffers
// the words in a small FIFO so the downstream accumulator can stall without losing data.
module add_stream_fetch #(
    parameter int          DEPTH      = 4,
    parameter logic [29:0] LAST_INDEX = 30'd15
) (
    input  logic              clk,
    input  logic              reset,
    add_stream_fetch_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [29:0]   r_index;
    logic [LW-1:0] r_level;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_mem [DEPTH];

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_last;

    // Fullness is judged on the current level only, so a full FIFO takes a one-cycle
    // bubble even when the accumulator pops in the same cycle.
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_valid = (r_level != '0);
    assign w_push  = (r_state == S_FETCH) && !w_full;
    assign w_pop   = w_valid && bus.out_ready && (r_state != S_DONE);
    assign w_last  = (r_index == LAST_INDEX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_index <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_push) begin
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_index <= r_index + 30'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_level == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset: the cleared pointers and level make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_tail] <= bus.mem_data;
        end
    end

    assign bus.mem_addr  = r_index;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? r_mem[r_head] : '0;
    assign bus.level     = r_level;
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_add_stream_fetch.sv
// Self-checking bench for add_stream_fetch: a per-cycle vector table for stall/full behaviour
// and a word scoreboard for full streams, drains and resets.
module tb_add_stream_fetch;
    logic clk;
    logic rst_a;
    logic rst_b;

    int n_vec;
    int n_err;

    logic [31:0] sb_q[$];

    add_stream_fetch_if #(.DEPTH(4)) bus_a ();
    add_stream_fetch_if #(.DEPTH(4)) bus_b ();

    add_stream_fetch #(.DEPTH(4), .LAST_INDEX(30'd15)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    add_stream_fetch #(.DEPTH(4), .LAST_INDEX(30'd3)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    // Combinational ROM: each word holds its own byte address.
    assign bus_a.mem_data = {bus_a.mem_addr, 2'b00};
    assign bus_b.mem_data = {bus_b.mem_addr, 2'b00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [2:0]  lvl;
        logic        vld;
        logic [31:0] dat;
        logic [29:0] addr;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_a(input logic rdy);
        rst_a = 1'b1;
        bus_a.out_ready = rdy;
        cyc();
        rst_a = 1'b0;
    endtask

    task automatic check_reset_state_a(input string name);
        check({name, "_valid"}, 0, 32'(bus_a.out_valid), 32'd0);
        check({name, "_data"},  0, bus_a.out_data, 32'd0);
        check({name, "_addr"},  0, 32'(bus_a.mem_addr), 32'd0);
        check({name, "_level"}, 0, 32'(bus_a.level), 32'd0);
        check({name, "_done"},  0, 32'(bus_a.done), 32'd0);
    endtask

    // Full 16-word stream with the accumulator always ready, starting from a reset pulse.
    task automatic run_stream(input string name);
        logic [31:0] exp;
        sb_q.delete();
        for (int unsigned i = 0; i < 16; i++) sb_q.push_back(32'(i * 4));
        reset_a(1'b1);
        check_reset_state_a({name, "_rst"});
        for (int unsigned c = 1; c <= 16; c++) begin
            cyc();
            check({name, "_valid"}, int'(c), 32'(bus_a.out_valid), 32'd1);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
            check({name, "_data"}, int'(c), bus_a.out_data, exp);
            check({name, "_done"}, int'(c), 32'(bus_a.done), 32'd0);
        end
        check({name, "_addr_hold"}, 16, 32'(bus_a.mem_addr), 32'd15);
        cyc();
        check({name, "_valid"}, 17, 32'(bus_a.out_valid), 32'd0);
        check({name, "_done"},  17, 32'(bus_a.done), 32'd0);
        cyc();
        check({name, "_done"},  18, 32'(bus_a.done), 32'd1);
        check({name, "_valid"}, 18, 32'(bus_a.out_valid), 32'd0);
        for (int unsigned c = 19; c < 22; c++) begin
            cyc();
            check({name, "_done_sticky"}, int'(c), 32'(bus_a.done), 32'd1);
            check({name, "_level"},       int'(c), 32'(bus_a.level), 32'd0);
            check({name, "_addr"},        int'(c), 32'(bus_a.mem_addr), 32'd15);
        end
        check({name, "_sb_left"}, 0, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] exp;
        n_vec = 0;
        n_err = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;

        //            rdy   lvl   vld   dat     addr
        tbl[0] = '{1'b0, 3'd1, 1'b1, 32'd0,  30'd1};
        tbl[1] = '{1'b0, 3'd2, 1'b1, 32'd0,  30'd2};
        tbl[2] = '{1'b0, 3'd3, 1'b1, 32'd0,  30'd3};
        tbl[3] = '{1'b0, 3'd4, 1'b1, 32'd0,  30'd4};
        tbl[4] = '{1'b0, 3'd4, 1'b1, 32'd0,  30'd4};
        tbl[5] = '{1'b1, 3'd3, 1'b1, 32'd4,  30'd4};
        tbl[6] = '{1'b0, 3'd4, 1'b1, 32'd4,  30'd5};
        tbl[7] = '{1'b1, 3'd3, 1'b1, 32'd8,  30'd5};
        tbl[8] = '{1'b1, 3'd3, 1'b1, 32'd12, 30'd6};
        tbl[9] = '{1'b1, 3'd3, 1'b1, 32'd16, 30'd7};

        repeat (2) @(posedge clk);
        @(negedge clk);

        // Stall from reset, then full-plus-pop bubble.
        reset_a(1'b0);
        check_reset_state_a("stall_rst");
        for (int unsigned i = 0; i < 10; i++) begin
            bus_a.out_ready = tbl[i].rdy;
            cyc();
            check("tbl_level", int'(i), 32'(bus_a.level), 32'(tbl[i].lvl));
            check("tbl_valid", int'(i), 32'(bus_a.out_valid), 32'(tbl[i].vld));
            check("tbl_data",  int'(i), bus_a.out_data, tbl[i].dat);
            check("tbl_addr",  int'(i), 32'(bus_a.mem_addr), 32'(tbl[i].addr));
            check("tbl_done",  int'(i), 32'(bus_a.done), 32'd0);
        end

        // Mid-stream reset with index 5 and level 2.
        reset_a(1'b0);
        cyc();
        cyc();
        bus_a.out_ready = 1'b1;
        repeat (3) cyc();
        check("mid_addr",  0, 32'(bus_a.mem_addr), 32'd5);
        check("mid_level", 0, 32'(bus_a.level), 32'd2);
        check("mid_data",  0, bus_a.out_data, 32'd12);
        reset_a(1'b0);
        check_reset_state_a("mid_rst");
        cyc();
        check("mid_restart_data",  0, bus_a.out_data, 32'd0);
        check("mid_restart_level", 0, 32'(bus_a.level), 32'd1);
        check("mid_restart_addr",  0, 32'(bus_a.mem_addr), 32'd1);

        run_stream("stream1");
        // Second pass starts with a reset while in DONE.
        run_stream("stream2");

        // Short stream (LAST_INDEX=3): fill, drain, done.
        rst_b = 1'b1;
        bus_b.out_ready = 1'b0;
        cyc();
        rst_b = 1'b0;
        check("drain_rst_addr",  0, 32'(bus_b.mem_addr), 32'd0);
        check("drain_rst_valid", 0, 32'(bus_b.out_valid), 32'd0);
        sb_q.delete();
        for (int unsigned i = 0; i < 4; i++) sb_q.push_back(32'(i * 4));
        repeat (5) cyc();
        check("drain_full_level", 0, 32'(bus_b.level), 32'd4);
        check("drain_full_addr",  0, 32'(bus_b.mem_addr), 32'd3);
        check("drain_full_data",  0, bus_b.out_data, 32'd0);
        for (int unsigned i = 0; i < 4; i++) begin
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
            check("drain_data",  int'(i), bus_b.out_data, exp);
            check("drain_level", int'(i), 32'(bus_b.level), 32'(4 - i));
            bus_b.out_ready = 1'b1;
            cyc();
            check("drain_addr", int'(i), 32'(bus_b.mem_addr), 32'd3);
        end
        check("drain_empty_valid", 0, 32'(bus_b.out_valid), 32'd0);
        check("drain_empty_done",  0, 32'(bus_b.done), 32'd0);
        cyc();
        check("drain_done",       0, 32'(bus_b.done), 32'd1);
        check("drain_done_valid", 0, 32'(bus_b.out_valid), 32'd0);
        check("drain_done_data",  0, bus_b.out_data, 32'd0);
        cyc();
        check("drain_done_level", 0, 32'(bus_b.level), 32'd0);
        check("drain_done_hold",  0, 32'(bus_b.done), 32'd1);
        check("drain_sb_left",    0, 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
